// File: rtl/gs_div_dispatcher_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gs_div_dispatcher_if : request / divider / response bundle for the   |
// | Goldschmidt divider issue stage.            Revision: 1.0            |
// +--------------------------------------------------------------------+
interface gs_div_dispatcher_if #(
   parameter int TAG_W = 4,
   parameter int LVL_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_num;
   logic [15:0]      in_den;
   logic [TAG_W-1:0] in_tag;

   logic             div_start;
   logic [15:0]      div_num;
   logic [15:0]      div_den;
   logic             div_valid;
   logic             div_error;
   logic [15:0]      div_quotient;

   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_quotient;
   logic [TAG_W-1:0] out_tag;
   logic [1:0]       out_status;

   logic [LVL_W-1:0] fifo_level;
   logic             busy;

   modport slave (
      input  in_valid, in_num, in_den, in_tag,
      input  div_valid, div_error, div_quotient,
      input  out_ready,
      output in_ready, div_start, div_num, div_den,
      output out_valid, out_quotient, out_tag, out_status,
      output fifo_level, busy
   );

   modport master (
      output in_valid, in_num, in_den, in_tag,
      output div_valid, div_error, div_quotient,
      output out_ready,
      input  in_ready, div_start, div_num, div_den,
      input  out_valid, out_quotient, out_tag, out_status,
      input  fifo_level, busy
   );
endinterface
`default_nettype wire

// File: rtl/gs_div_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gs_div_dispatcher : FIFO-buffered issue stage for the Q4.12          |
// | Goldschmidt divider with div-by-zero bypass and watchdog.            |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module gs_div_dispatcher #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 32
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   gs_div_dispatcher_if.slave dsp_io
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam int ENT_W = 32 + TAG_W;

   localparam logic [1:0] C_ST_OK  = 2'b00;
   localparam logic [1:0] C_ST_DBZ = 2'b01;
   localparam logic [1:0] C_ST_TMO = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q;

   state_e           state_q, state_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [15:0]      quot_q, quot_d;
   logic [1:0]       status_q, status_d;
   logic [15:0]      dnum_q, dnum_d;
   logic [15:0]      dden_q, dden_d;

   logic             in_ready;
   logic             push;
   logic             pop;
   logic             div_start;
   logic [15:0]      head_num, head_den;
   logic [TAG_W-1:0] head_tag;

   assign in_ready = (level_q != LVL_W'(DEPTH));
   assign push     = dsp_io.in_valid && in_ready;
   assign {head_tag, head_den, head_num} = mem_q[rd_ptr_q];

   // Storage needs no reset: the level counter alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {dsp_io.in_tag, dsp_io.in_den, dsp_io.in_num};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         state_q  <= S_IDLE;
         wd_q     <= '0;
         tag_q    <= '0;
         quot_q   <= '0;
         status_q <= C_ST_OK;
         dnum_q   <= '0;
         dden_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
         state_q  <= state_d;
         wd_q     <= wd_d;
         tag_q    <= tag_d;
         quot_q   <= quot_d;
         status_q <= status_d;
         dnum_q   <= dnum_d;
         dden_q   <= dden_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wd_d      = wd_q;
      tag_d     = tag_q;
      quot_d    = quot_q;
      status_d  = status_q;
      dnum_d    = dnum_q;
      dden_d    = dden_q;
      pop       = 1'b0;
      div_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (level_q != '0) begin
               pop   = 1'b1;
               tag_d = head_tag;
               // Zero denominators never reach the divider, so the divider-facing
               // operands keep showing the last op actually issued.
               if (head_den == 16'h0000) begin
                  quot_d   = 16'h0000;
                  status_d = C_ST_DBZ;
                  state_d  = S_RESP;
               end else begin
                  dnum_d  = head_num;
                  dden_d  = head_den;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            div_start = 1'b1;
            wd_d      = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + WD_W'(1);
            if (dsp_io.div_valid) begin
               quot_d   = dsp_io.div_error ? 16'h0000 : dsp_io.div_quotient;
               status_d = dsp_io.div_error ? C_ST_DBZ : C_ST_OK;
               state_d  = S_RESP;
            end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
               quot_d   = 16'h0000;
               status_d = C_ST_TMO;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (dsp_io.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dsp_io.in_ready     = in_ready;
   assign dsp_io.div_start    = div_start;
   assign dsp_io.div_num      = dnum_q;
   assign dsp_io.div_den      = dden_q;
   assign dsp_io.out_valid    = (state_q == S_RESP);
   assign dsp_io.out_quotient = quot_q;
   assign dsp_io.out_tag      = tag_q;
   assign dsp_io.out_status   = status_q;
   assign dsp_io.fifo_level   = level_q;
   assign dsp_io.busy         = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_gs_div_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gs_div_dispatcher : directed vector bench with a latency-driven   |
// | divider model.                              Revision: 1.0            |
// +--------------------------------------------------------------------+
module tb_gs_div_dispatcher;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int TIMEOUT = 32;
   localparam int LVL_W   = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   gs_div_dispatcher_if #(.TAG_W(TAG_W), .LVL_W(LVL_W)) bus ();

   gs_div_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .dsp_io (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Divider model: answers m_lat cycles after the start pulse unless silenced.
   int          m_lat    = 1;
   logic        m_silent = 1'b0;
   logic        m_stray  = 1'b0;
   logic [15:0] m_dq     = 16'h0;
   logic        m_derr   = 1'b0;
   int          start_cnt = 0;
   int          pend      = 0;
   logic [15:0] cap_num   = 16'h0;
   logic [15:0] cap_den   = 16'h0;

   initial begin
      bus.div_valid    = 1'b0;
      bus.div_error    = 1'b0;
      bus.div_quotient = 16'h0;
      forever begin
         @(posedge clk); #1;
         bus.div_valid = 1'b0;
         if (!rst_n) pend = 0;
         if (m_stray) begin
            bus.div_valid    = 1'b1;
            bus.div_error    = 1'b0;
            bus.div_quotient = 16'hBEEF;
            m_stray          = 1'b0;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.div_valid    = 1'b1;
               bus.div_error    = m_derr;
               bus.div_quotient = m_dq;
            end
         end
         if (bus.div_start) begin
            start_cnt++;
            cap_num = bus.div_num;
            cap_den = bus.div_den;
            if (!m_silent) pend = m_lat;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [15:0] n, input logic [15:0] d, input logic [TAG_W-1:0] t);
      bus.in_valid = 1'b1;
      bus.in_num   = n;
      bus.in_den   = d;
      bus.in_tag   = t;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(input int budget, output int cycles);
      cycles = 0;
      while (!bus.out_valid && cycles < budget) begin
         tick();
         cycles++;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   typedef struct {
      logic [15:0]      num;
      logic [15:0]      den;
      logic [TAG_W-1:0] tag;
      int               lat;
      logic [15:0]      dq;
      logic             derr;
      logic [15:0]      exp_q;
      logic [1:0]       exp_st;
      int               exp_starts;
      int               exp_cyc;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int cyc;
      int s0;
      logic acc;
      logic seen;

      // Cycle counts are measured from the push edge to the first cycle with out_valid.
      vecs[0] = '{16'h2000, 16'h1000, 4'd3,  1,  16'h2000, 1'b0, 16'h2000, 2'b00, 1, 3};
      vecs[1] = '{16'h1800, 16'h0000, 4'd5,  1,  16'h7777, 1'b0, 16'h0000, 2'b01, 0, 1};
      vecs[2] = '{16'h1000, 16'h4000, 4'd7,  2,  16'h0400, 1'b0, 16'h0400, 2'b00, 1, 4};
      vecs[3] = '{16'h3000, 16'h1800, 4'd9,  3,  16'h1234, 1'b1, 16'h0000, 2'b01, 1, 5};
      vecs[4] = '{16'hFFFF, 16'h0001, 4'd15, 1,  16'hFFFF, 1'b0, 16'hFFFF, 2'b00, 1, 3};
      vecs[5] = '{16'h0000, 16'h0000, 4'd0,  1,  16'h5555, 1'b0, 16'h0000, 2'b01, 0, 1};
      vecs[6] = '{16'h0800, 16'h1000, 4'd2,  TIMEOUT, 16'h0800, 1'b0, 16'h0800, 2'b00, 1, TIMEOUT + 2};

      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_num   = 16'h0;
      bus.in_den   = 16'h0;
      bus.in_tag   = '0;
      bus.out_ready = 1'b0;
      repeat (3) tick();
      check("rst in_ready",   32'(bus.in_ready), 32'd1);
      check("rst out_valid",  32'(bus.out_valid), 32'd0);
      check("rst div_start",  32'(bus.div_start), 32'd0);
      check("rst fifo_level", 32'(bus.fifo_level), 32'd0);
      check("rst busy",       32'(bus.busy), 32'd0);
      check("rst out_bus",    {bus.out_quotient, 10'd0, bus.out_tag, bus.out_status}, 32'd0);
      check("rst div_ops",    {bus.div_num, bus.div_den}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         m_lat    = vecs[i].lat;
         m_dq     = vecs[i].dq;
         m_derr   = vecs[i].derr;
         m_silent = 1'b0;
         s0       = start_cnt;
         push(vecs[i].num, vecs[i].den, vecs[i].tag);
         wait_out(80, cyc);
         check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd1);
         check($sformatf("v%0d latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         check($sformatf("v%0d quotient", i), 32'(bus.out_quotient), 32'(vecs[i].exp_q));
         check($sformatf("v%0d tag", i), 32'(bus.out_tag), 32'(vecs[i].tag));
         check($sformatf("v%0d status", i), 32'(bus.out_status), 32'(vecs[i].exp_st));
         check($sformatf("v%0d starts", i), 32'(start_cnt - s0), 32'(vecs[i].exp_starts));
         if (vecs[i].exp_starts != 0)
            check($sformatf("v%0d div_ops", i), {cap_num, cap_den}, {vecs[i].num, vecs[i].den});
         consume();
         check($sformatf("v%0d released", i), {31'd0, bus.out_valid}, 32'd0);
      end

      // Divider error held under backpressure: the response must not move.
      m_lat = 2; m_dq = 16'h5555; m_derr = 1'b1;
      push(16'h3000, 16'h1800, 4'd9);
      wait_out(40, cyc);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("err hold %0d", k),
               {11'd0, bus.out_valid, bus.out_quotient, bus.out_tag, bus.out_status},
               {11'd0, 1'b1, 16'h0000, 4'd9, 2'b01});
         tick();
      end
      consume();
      m_derr = 1'b0;

      // Backpressure: one op in flight plus DEPTH queued, sixth refused.
      m_lat = 1; m_dq = 16'h1000;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_num   = 16'(i + 1);
         bus.in_den   = 16'h1000;
         bus.in_tag   = 4'(i);
         acc = bus.in_ready;
         tick();
         check($sformatf("bp accept %0d", i), 32'(acc), 32'(i < 5));
      end
      bus.in_valid = 1'b0;
      check("bp level full", 32'(bus.fifo_level), 32'(DEPTH));
      check("bp in_ready",   32'(bus.in_ready), 32'd0);
      check("bp head resp",  32'(bus.out_valid), 32'd1);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_out(40, cyc);
         check($sformatf("bp out %0d", k), {26'd0, bus.out_valid, bus.out_tag, bus.out_status},
               {26'd0, 1'b1, 4'(k), 2'b00});
         tick();
      end
      bus.out_ready = 1'b0;
      wait_out(20, cyc);
      check("bp no extra", 32'(bus.out_valid), 32'd0);

      // Silent divider: watchdog fires after TIMEOUT cycles in WAIT.
      m_silent = 1'b1;
      push(16'h1000, 16'h1000, 4'd6);
      wait_out(100, cyc);
      check("tmo latency", 32'(cyc), 32'(TIMEOUT + 2));
      check("tmo resp", {13'd0, bus.out_valid, bus.out_quotient, bus.out_status},
            {13'd0, 1'b1, 16'h0000, 2'b10});
      m_stray = 1'b1;
      repeat (3) tick();
      check("tmo stray in RESP", {11'd0, bus.out_valid, bus.out_quotient, bus.out_tag, bus.out_status},
            {11'd0, 1'b1, 16'h0000, 4'd6, 2'b10});
      consume();
      m_stray = 1'b1;
      repeat (3) tick();
      check("tmo stray in IDLE", {30'd0, bus.busy, bus.out_valid}, 32'd0);

      // Reset while waiting with three entries queued.
      for (int i = 0; i < 4; i++) push(16'h1000, 16'h1000, 4'(8 + i));
      tick();
      check("mid busy",  32'(bus.busy), 32'd1);
      check("mid level", 32'(bus.fifo_level), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("mid rst in_ready", 32'(bus.in_ready), 32'd1);
      check("mid rst level",    32'(bus.fifo_level), 32'd0);
      check("mid rst ctl",      {29'd0, bus.busy, bus.out_valid, bus.div_start}, 32'd0);
      check("mid rst out_bus",  {bus.out_quotient, 10'd0, bus.out_tag, bus.out_status}, 32'd0);
      check("mid rst div_ops",  {bus.div_num, bus.div_den}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      m_silent = 1'b0;
      seen     = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         if (bus.out_valid || bus.div_start) seen = 1'b1;
      end
      check("post rst quiet", 32'(seen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global time limit reached");
      $fatal(1);
   end
endmodule
`default_nettype wire
